// File: rtl/conv_result_writer.sv
// Convolution write-back: clips MAC results to pixel width, queues them in a 2-entry FIFO
// and writes them row-major to the result frame. Define CENTER_ADDR_EN for kernel-centre addressing.
module conv_result_writer #(
    parameter int unsigned W      = 220,
    parameter int unsigned H      = 220,
    parameter int unsigned DW_IN  = 20,
    parameter int unsigned DW_OUT = 8,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [3:0]              m,
    input  logic                    res_valid,
    input  logic signed [DW_IN-1:0] res_data,
    output logic                    res_ready,
    input  logic                    mem_ready,
    output logic                    wr_en,
    output logic [15:0]             wr_addr,
    output logic [DW_OUT-1:0]       wr_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             pix_count
);

    localparam int unsigned EW = 16 + DW_OUT;
    localparam logic signed [DW_IN-1:0] MaxV = DW_IN'((1 << DW_OUT) - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e      state_q;
    logic [3:0]  m_q;
    logic [15:0] col_q, row_q;
    logic [15:0] ow, oh;
    logic        last_pos;

    logic [EW-1:0] fifo_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    count_q;
    logic          push, pop;

    logic signed [DW_IN-1:0] shifted;
    logic [DW_OUT-1:0]       clipped;
    logic [15:0]             addr;

    assign ow       = 16'(W) - {12'd0, m_q} + 16'd1;
    assign oh       = 16'(H) - {12'd0, m_q} + 16'd1;
    assign last_pos = (col_q == ow - 16'd1) && (row_q == oh - 16'd1);

    assign res_ready = (state_q == StRun) && (count_q != 2'd2);
    assign push      = res_valid && res_ready;
    assign wr_en     = (count_q != 2'd0);
    assign pop       = wr_en && mem_ready;
    assign {wr_addr, wr_data} = fifo_q[rd_ptr_q];

    always_comb begin
        shifted = res_data >>> SHIFT;
        if (shifted < 0) begin
            clipped = '0;
        end else if (shifted > MaxV) begin
            clipped = '1;
        end else begin
            clipped = shifted[DW_OUT-1:0];
        end
    end

`ifdef CENTER_ADDR_EN
    logic [3:0]  half4;
    logic [15:0] half;
    assign half4 = (m_q - 4'd1) >> 1;
    assign half  = {12'd0, half4};
    assign addr  = (row_q + half) * 16'(W) + col_q + half;
`else
    assign addr = row_q * ow + col_q;
`endif

    // Frame control: position counters, latched kernel size and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            m_q        <= 4'd1;
            col_q      <= '0;
            row_q      <= '0;
            pix_count  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        m_q       <= (m == 4'd0) ? 4'd1 : m;
                        col_q     <= '0;
                        row_q     <= '0;
                        pix_count <= '0;
                        busy      <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (push) begin
                        pix_count <= pix_count + 16'd1;
                        if (col_q == ow - 16'd1) begin
                            col_q <= '0;
                            row_q <= row_q + 16'd1;
                        end else begin
                            col_q <= col_q + 16'd1;
                        end
                        if (last_pos) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (count_q == 2'd0) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    frame_done <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Two-entry FIFO; the head only moves on a pop, so it holds under back-pressure.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {addr, clipped};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed self-checking bench for conv_result_writer: 8x8 instance for framing/addressing,
// 4x4 SHIFT=2 instance for clipping.
module tb_conv_result_writer;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 8x8, SHIFT=0
    logic               start = 0, res_valid = 0, mem_ready = 0;
    logic [3:0]         m = 4'd3;
    logic signed [19:0] res_data = '0;
    logic               res_ready, wr_en, busy, frame_done;
    logic [15:0]        wr_addr, pix_count;
    logic [7:0]         wr_data;

    // Instance B: 4x4, SHIFT=2
    logic               start_b = 0, res_valid_b = 0, mem_ready_b = 1;
    logic [3:0]         m_b = 4'd3;
    logic signed [19:0] res_data_b = '0;
    logic               res_ready_b, wr_en_b, busy_b, frame_done_b;
    logic [15:0]        wr_addr_b, pix_count_b;
    logic [7:0]         wr_data_b;

    conv_result_writer #(.W(8), .H(8), .DW_IN(20), .DW_OUT(8), .SHIFT(0)) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .m(m), .res_valid(res_valid),
        .res_data(res_data), .res_ready(res_ready), .mem_ready(mem_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
        .pix_count(pix_count)
    );

    conv_result_writer #(.W(4), .H(4), .DW_IN(20), .DW_OUT(8), .SHIFT(2)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .m(m_b), .res_valid(res_valid_b),
        .res_data(res_data_b), .res_ready(res_ready_b), .mem_ready(mem_ready_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b),
        .frame_done(frame_done_b), .pix_count(pix_count_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;
    int exp_m    = 3;
    int dmul     = 1;
    int doff     = 0;
    logic [23:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_addr(input int p, input int w, input int mm);
        int ow, row, col, h;
        ow  = w - mm + 1;
        row = p / ow;
        col = p % ow;
        h   = (mm - 1) / 2;
`ifdef CENTER_ADDR_EN
        return 16'((row + h) * w + col + h);
`else
        if (h < 0) return 16'hffff;
        return 16'(row * ow + col);
`endif
    endfunction

    function automatic logic [7:0] model_clip(input logic signed [19:0] d, input int sh);
        int v;
        v = int'(d) >>> sh;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic logic signed [19:0] data_of(input int p);
        return 20'((p * dmul + doff) % 256);
    endfunction

    // One cycle on instance A: drive at negedge, check the write port against the scoreboard.
    task automatic step(input logic v, input logic signed [19:0] d, input logic mr,
                        output logic acc);
        @(negedge clk);
        res_valid = v;
        res_data  = d;
        mem_ready = mr;
        check("wr_en_occupancy", 32'(wr_en), 32'(exp_q.size() != 0));
        if (wr_en === 1'b1 && exp_q.size() != 0) begin
            check("wr_addr", 32'(wr_addr), 32'(exp_q[0][23:8]));
            check("wr_data", 32'(wr_data), 32'(exp_q[0][7:0]));
            if (mr) void'(exp_q.pop_front());
        end
        acc = v && (res_ready === 1'b1);
        if (acc) begin
            exp_q.push_back({model_addr(pos, 8, exp_m), model_clip(d, 0)});
            pos++;
        end
    endtask

    // mode 0: mem_ready low, 1: high, 2: low every third cycle
    task automatic stream(input int n, input int mode);
        int   guard;
        logic mr, acc;
        guard = 0;
        while (pos < n && guard < 500) begin
            mr = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (guard % 3 != 0);
            step(1'b1, data_of(pos), mr, acc);
            guard++;
        end
        check("stream_count", 32'(pos), 32'(n));
    endtask

    task automatic start_frame(input int mm);
        @(negedge clk);
        res_valid = 0;
        start     = 1;
        m         = 4'(mm);
        @(negedge clk);
        start = 0;
        exp_m = (mm == 0) ? 1 : mm;
        pos   = 0;
        exp_q.delete();
        check("start_busy", 32'(busy), 32'd1);
        check("start_pix_clear", 32'(pix_count), 32'd0);
        check("start_res_ready", 32'(res_ready), 32'd1);
    endtask

    task automatic drain_and_finish(input int npix);
        int   guard;
        logic acc, first;
        guard = 0;
        first = 1;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1'b0, '0, 1'b1, acc);
            if (first) check("drain_res_ready", 32'(res_ready), 32'd0);
            first = 0;
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_not_yet", 32'(frame_done), 32'd0);
        check("done_wr_en_low", 32'(wr_en), 32'd0);
        check("done_busy_still", 32'(busy), 32'd1);
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_pix_count", 32'(pix_count), 32'(npix));
        @(negedge clk);
        check("frame_done_one_cycle", 32'(frame_done), 32'd0);
        check("pix_count_hold", 32'(pix_count), 32'(npix));
    endtask

    initial begin
        logic acc;
        int   nacc;
        int   found;
        logic signed [19:0] b_vals [4];
        logic [7:0]         b_exp  [4];
        b_vals = '{-20'sd5, 20'sd1023, 20'sd1024, 20'sd12};
        b_exp  = '{8'd0, 8'd255, 8'd255, 8'd3};

        // Reset state
        repeat (2) @(negedge clk);
        rstn = 1;
        check("rst_res_ready", 32'(res_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_pix_count", 32'(pix_count), 32'd0);
        check("rst_b_wr_en", 32'(wr_en_b), 32'd0);

        // Frame 1: 36 back-to-back values 0..35; start and m=5 during RUN are ignored
        start_frame(3);
        stream(10, 1);
        start = 1;
        m     = 4'd5;
        stream(11, 1);
        start = 0;
        stream(36, 1);
        drain_and_finish(36);

        // Frame 2: back-pressure with the FIFO filling to two entries
        dmul = 7;
        doff = 3;
        start_frame(3);
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, data_of(pos), 1'b0, acc);
            if (acc) nacc++;
        end
        check("bp_accepted", 32'(nacc), 32'd2);
        check("bp_res_ready_low", 32'(res_ready), 32'd0);
        check("bp_pix_count", 32'(pix_count), 32'd2);
        check("bp_head_addr", 32'(wr_addr), 32'(model_addr(0, 8, 3)));
        check("bp_head_data", 32'(wr_data), 32'd3);
        stream(36, 2);
        drain_and_finish(36);

        // Frame 3: reset mid-frame with two entries queued
        start_frame(3);
        stream(2, 0);
        @(negedge clk);
        res_valid = 0;
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        check("pre_rst_full", 32'(res_ready), 32'd0);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pix_count", 32'(pix_count), 32'd0);
        exp_q.delete();

        // Frame 4: m=5 gives a 4x4 output frame
        dmul = 13;
        doff = 1;
        start_frame(5);
        stream(16, 2);
        drain_and_finish(16);

        // Instance B: clipping with SHIFT=2, 2x2 output
        @(negedge clk);
        start_b = 1;
        m_b     = 4'd3;
        @(negedge clk);
        start_b     = 0;
        res_valid_b = 1;
        res_data_b  = b_vals[0];
        check("b_busy", 32'(busy_b), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_wr_en", 32'(wr_en_b), 32'd1);
            check("b_wr_data", 32'(wr_data_b), 32'(b_exp[i]));
            check("b_wr_addr", 32'(wr_addr_b), 32'(model_addr(i, 4, 3)));
            if (i < 3) res_data_b = b_vals[i + 1];
            else res_valid_b = 0;
        end
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (frame_done_b === 1'b1) found = 1;
        end
        check("b_frame_done", 32'(found), 32'd1);
        check("b_pix_count", 32'(pix_count_b), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
